// File: rtl/handshake_reader.sv
// handshake_reader: captures bytes from an asynchronous 4-phase request/ack
// pin interface into a small queue and replays them as one-cycle strobes.
// A capture with reset_hash set flushes the queue and emits reset_hash_pulse.
// Optional build macro READER_TIMEOUT_EN adds a sticky request-hold error.
module handshake_reader #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             input_byte,
    input  logic                          is_key,
    input  logic                          reset_hash,
    input  logic                          input_request,
    output logic                          input_ack,
    input  logic                          accept_en,
    input  logic                          out_ready,
    output logic [DATA_W-1:0]             input_byte_pulsed,
    output logic                          is_key_pulsed,
    output logic                          input_byte_pulse,
    output logic                          reset_hash_pulse,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          timeout_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DATA_W + 1;

    typedef enum logic {
        WAIT_REQ  = 1'b0,
        WAIT_DROP = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                  w_req_s;

    logic [EW-1:0]         r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wptr;
    logic [AW-1:0]         r_rptr;
    logic [CW-1:0]         r_count;
    logic [EW-1:0]         w_head;

    logic                  w_full;
    logic                  w_capture;
    logic                  w_push;
    logic                  w_flush;
    logic                  w_pop;

    logic [DATA_W-1:0]     r_byte_p;
    logic                  r_key_p;
    logic                  r_pulse;
    logic                  r_rh_pulse;

    assign w_req_s = r_sync[SYNC_STAGES-1];
    assign w_full  = (r_count == CW'(FIFO_DEPTH));
    assign w_head  = r_mem[r_rptr];
    assign w_flush = w_capture & reset_hash;
    assign w_push  = w_capture & ~reset_hash;
    // A flush wins over a pop in the same cycle, so no stale byte escapes.
    assign w_pop   = (r_count != '0) & out_ready & ~w_flush;

    // Request synchroniser; nothing else looks at the raw input_request.
    always_ff @(posedge clk) begin
        if (rst) r_sync <= '0;
        else     r_sync <= {r_sync[SYNC_STAGES-2:0], input_request};
    end

    // Handshake state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= WAIT_REQ;
        else     r_state <= w_state_next;
    end

    // Next-state and capture decision.
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        case (r_state)
            WAIT_REQ: begin
                if (w_req_s && accept_en && (reset_hash || !w_full)) begin
                    w_capture    = 1'b1;
                    w_state_next = WAIT_DROP;
                end
            end
            WAIT_DROP: begin
                if (!w_req_s) w_state_next = WAIT_REQ;
            end
            default: w_state_next = WAIT_REQ;
        endcase
    end

    assign input_ack = (r_state == WAIT_DROP);

    // Queue storage; stale contents are harmless because pointers are reset.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= {input_byte, is_key};
    end

    // Queue pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge clk) begin
        if (rst || w_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Registered output strobes; data outputs are zero when not pulsing.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pulse    <= 1'b0;
            r_byte_p   <= '0;
            r_key_p    <= 1'b0;
            r_rh_pulse <= 1'b0;
        end else begin
            r_pulse    <= w_pop;
            r_byte_p   <= w_pop ? w_head[EW-1:1] : '0;
            r_key_p    <= w_pop & w_head[0];
            r_rh_pulse <= w_flush;
        end
    end

    assign input_byte_pulse  = r_pulse;
    assign input_byte_pulsed = r_byte_p;
    assign is_key_pulsed     = r_key_p;
    assign reset_hash_pulse  = r_rh_pulse;
    assign fifo_count        = r_count;

`ifdef READER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] r_tcnt;
    logic          r_terr;

    // Count cycles spent waiting for the request to drop; flag a hold too long.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tcnt <= '0;
            r_terr <= 1'b0;
        end else begin
            if (r_state == WAIT_DROP) begin
                if (r_tcnt != TW'(TIMEOUT_CYC)) r_tcnt <= r_tcnt + 1'b1;
            end else begin
                r_tcnt <= '0;
            end
            if (w_flush)
                r_terr <= 1'b0;
            else if ((r_state == WAIT_DROP) && w_req_s && (r_tcnt == TW'(TIMEOUT_CYC)))
                r_terr <= 1'b1;
        end
    end

    assign timeout_err = r_terr;
`else
    // No hold counter in this build; the parameter is referenced only so it
    // stays part of the interface without affecting logic.
    assign timeout_err = 1'b0 & (TIMEOUT_CYC != 0);
`endif

endmodule

// File: tb/tb_handshake_reader.sv
// Self-checking bench for handshake_reader. Expected values come from a
// queue-based model of the byte stream; define READER_TIMEOUT_EN to exercise
// the hold-timeout build.
module tb_handshake_reader;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int TOC   = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] input_byte = '0;
    logic          is_key = 1'b0;
    logic          reset_hash = 1'b0;
    logic          input_request = 1'b0;
    logic          input_ack;
    logic          accept_en = 1'b1;
    logic          out_ready = 1'b0;
    logic [DW-1:0] input_byte_pulsed;
    logic          is_key_pulsed;
    logic          input_byte_pulse;
    logic          reset_hash_pulse;
    logic [2:0]    fifo_count;
    logic          timeout_err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int rh_cnt = 0;
    int max_cnt = 0;
    logic [8:0] obs_q[$];
    logic [8:0] exp_q[$];

    handshake_reader #(
        .DATA_W(DW), .SYNC_STAGES(2), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TOC)
    ) dut (
        .clk(clk), .rst(rst), .input_byte(input_byte), .is_key(is_key),
        .reset_hash(reset_hash), .input_request(input_request), .input_ack(input_ack),
        .accept_en(accept_en), .out_ready(out_ready),
        .input_byte_pulsed(input_byte_pulsed), .is_key_pulsed(is_key_pulsed),
        .input_byte_pulse(input_byte_pulse), .reset_hash_pulse(reset_hash_pulse),
        .fifo_count(fifo_count), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every output strobe, sampled away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (input_byte_pulse) obs_q.push_back({input_byte_pulsed, is_key_pulsed});
            if (reset_hash_pulse) rh_cnt++;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    // Full 4-phase handshake; updates the expected stream when the ack shows
    // the capture happened.
    task automatic hs(input logic [7:0] b, input logic k, input logic rh,
                      input int hold, input bit rnd, output bit ok);
        int t;
        ok = 1'b1;
        @(negedge clk);
        input_byte = b; is_key = k; reset_hash = rh; input_request = 1'b1;
        t = 0;
        while (!input_ack && t < 200) begin
            @(negedge clk);
            t++;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
        end
        if (!input_ack) ok = 1'b0;
        else if (rh) begin
            while (exp_q.size() > obs_q.size()) void'(exp_q.pop_back());
        end else exp_q.push_back({b, k});
        repeat (hold) begin
            @(negedge clk);
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
        end
        input_request = 1'b0;
        t = 0;
        while (input_ack && t < 50) begin
            @(negedge clk);
            t++;
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
        end
        if (input_ack) ok = 1'b0;
        reset_hash = 1'b0;
    endtask

    task automatic pulse_rst();
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (input_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b want 0", input_ack); end
        n_cmp++; if (input_byte_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_pulse: got %b want 0", input_byte_pulse); end
        n_cmp++; if (input_byte_pulsed !== 8'h00) begin n_bad++; $display("FAIL reset_byte: got %h want 00", input_byte_pulsed); end
        n_cmp++; if (is_key_pulsed !== 1'b0) begin n_bad++; $display("FAIL reset_key: got %b want 0", is_key_pulsed); end
        n_cmp++; if (reset_hash_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_rhp: got %b want 0", reset_hash_pulse); end
        n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL reset_terr: got %b want 0", timeout_err); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        int e;
        int r0;
        out_ready = 1'b1; accept_en = 1'b1;
        repeat (3) @(negedge clk);
        obs_q.delete();
        r0 = rh_cnt;
        e = cyc;
        input_byte = 8'hA5; is_key = 1'b1; reset_hash = 1'b0; input_request = 1'b1;
        for (int d = 1; d <= 12; d++) begin
            @(negedge clk);
            case (cyc - e)
                2: begin
                    n_cmp++; if (input_ack !== 1'b0) begin n_bad++; $display("FAIL single_ack_early: got %b want 0", input_ack); end
                end
                3: begin
                    n_cmp++; if (input_ack !== 1'b1) begin n_bad++; $display("FAIL single_ack_rise: got %b want 1", input_ack); end
                    n_cmp++; if (fifo_count !== 3'd1) begin n_bad++; $display("FAIL single_count: got %0d want 1", fifo_count); end
                    n_cmp++; if (input_byte_pulse !== 1'b0) begin n_bad++; $display("FAIL single_pulse_early: got %b want 0", input_byte_pulse); end
                end
                4: begin
                    n_cmp++; if (input_byte_pulse !== 1'b1) begin n_bad++; $display("FAIL single_pulse: got %b want 1", input_byte_pulse); end
                    n_cmp++; if ({input_byte_pulsed, is_key_pulsed} !== {8'hA5, 1'b1}) begin n_bad++; $display("FAIL single_data: got %h/%b want a5/1", input_byte_pulsed, is_key_pulsed); end
                end
                5: begin
                    n_cmp++; if (input_byte_pulse !== 1'b0) begin n_bad++; $display("FAIL single_pulse_len: got %b want 0", input_byte_pulse); end
                    n_cmp++; if (input_byte_pulsed !== 8'h00) begin n_bad++; $display("FAIL single_idle_byte: got %h want 00", input_byte_pulsed); end
                    input_request = 1'b0;
                end
                7: begin
                    n_cmp++; if (input_ack !== 1'b1) begin n_bad++; $display("FAIL single_ack_hold: got %b want 1", input_ack); end
                end
                8: begin
                    n_cmp++; if (input_ack !== 1'b0) begin n_bad++; $display("FAIL single_ack_fall: got %b want 0", input_ack); end
                end
                default: ;
            endcase
        end
        #1;
        n_cmp++; if (obs_q.size() != 1) begin n_bad++; $display("FAIL single_npulses: got %0d want 1", obs_q.size()); end
        n_cmp++; if (rh_cnt != r0) begin n_bad++; $display("FAIL single_rhp: got %0d want %0d", rh_cnt, r0); end
    endtask

    task automatic test_long_hold();
        logic [7:0] b;
        int t;
        int hi;
        b = 8'($urandom);
        obs_q.delete();
        @(negedge clk);
        input_byte = b; is_key = 1'b0; input_request = 1'b1;
        t = 0;
        while (!input_ack && t < 50) begin @(negedge clk); t++; end
        hi = 0;
        for (int i = 0; i < 50; i++) begin @(negedge clk); if (input_ack) hi++; end
        n_cmp++; if (hi != 50) begin n_bad++; $display("FAIL long_ack_held: got %0d want 50", hi); end
        input_request = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        n_cmp++; if (obs_q.size() != 1) begin n_bad++; $display("FAIL long_npulses: got %0d want 1", obs_q.size()); end
        else begin
            n_cmp++; if (obs_q[0] !== {b, 1'b0}) begin n_bad++; $display("FAIL long_data: got %h want %h", obs_q[0], {b, 1'b0}); end
        end
    endtask

    task automatic test_fifo_full();
        bit ok;
        logic [7:0] b5;
        int t;
        int hi;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        obs_q.delete(); exp_q.delete();
        for (int i = 0; i < DEPTH; i++) begin
            hs(8'($urandom), 1'($urandom), 1'b0, $urandom_range(0, 2), 1'b0, ok);
            n_cmp++; if (!ok) begin n_bad++; $display("FAIL full_hs%0d: got no ack want ack", i); end
        end
        #1;
        n_cmp++; if (fifo_count !== 3'd4) begin n_bad++; $display("FAIL full_count: got %0d want 4", fifo_count); end
        b5 = 8'($urandom);
        @(negedge clk);
        input_byte = b5; is_key = 1'b1; input_request = 1'b1;
        hi = 0;
        repeat (20) begin @(negedge clk); if (input_ack) hi++; end
        n_cmp++; if (hi != 0) begin n_bad++; $display("FAIL full_ack_withheld: got %0d ack cycles want 0", hi); end
        n_cmp++; if (fifo_count !== 3'd4) begin n_bad++; $display("FAIL full_count_stall: got %0d want 4", fifo_count); end
        out_ready = 1'b1;
        t = 0;
        while (!input_ack && t < 50) begin @(negedge clk); t++; end
        n_cmp++; if (input_ack !== 1'b1) begin n_bad++; $display("FAIL full_5th_ack: got %b want 1", input_ack); end
        exp_q.push_back({b5, 1'b1});
        input_request = 1'b0;
        repeat (15) @(negedge clk);
        #1;
        n_cmp++; if (obs_q.size() != 5) begin n_bad++; $display("FAIL full_npulses: got %0d want 5", obs_q.size()); end
        for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
            n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL full_order%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL full_drained: got %0d want 0", fifo_count); end
    endtask

    task automatic test_reset_hash();
        bit ok;
        int r0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        obs_q.delete(); exp_q.delete();
        hs(8'($urandom), 1'b0, 1'b0, 1, 1'b0, ok);
        hs(8'($urandom), 1'b1, 1'b0, 1, 1'b0, ok);
        #1;
        n_cmp++; if (fifo_count !== 3'd2) begin n_bad++; $display("FAIL rh_pre_count: got %0d want 2", fifo_count); end
        r0 = rh_cnt;
        hs(8'($urandom), 1'b0, 1'b1, 1, 1'b0, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL rh_ack: got no ack want ack"); end
        #1;
        n_cmp++; if (rh_cnt - r0 != 1) begin n_bad++; $display("FAIL rh_pulse_cycles: got %0d want 1", rh_cnt - r0); end
        n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL rh_flush: got %0d want 0", fifo_count); end
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL rh_no_bytes: got %0d want 0", obs_q.size()); end
    endtask

    task automatic test_accept_en();
        logic [7:0] b;
        int hi;
        int t;
        b = 8'($urandom);
        out_ready = 1'b1; accept_en = 1'b0;
        repeat (3) @(negedge clk);
        obs_q.delete();
        input_byte = b; is_key = 1'b1; input_request = 1'b1;
        hi = 0;
        repeat (15) begin @(negedge clk); if (input_ack) hi++; end
        n_cmp++; if (hi != 0) begin n_bad++; $display("FAIL acc_blocked: got %0d ack cycles want 0", hi); end
        accept_en = 1'b1;
        t = 0;
        while (!input_ack && t < 50) begin @(negedge clk); t++; end
        n_cmp++; if (input_ack !== 1'b1) begin n_bad++; $display("FAIL acc_ack: got %b want 1", input_ack); end
        input_request = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        n_cmp++; if (obs_q.size() != 1) begin n_bad++; $display("FAIL acc_npulses: got %0d want 1", obs_q.size()); end
        else begin
            n_cmp++; if (obs_q[0] !== {b, 1'b1}) begin n_bad++; $display("FAIL acc_data: got %h want %h", obs_q[0], {b, 1'b1}); end
        end
    endtask

    task automatic test_rst_mid();
        logic [7:0] b;
        int t;
        b = 8'($urandom);
        out_ready = 1'b0;
        @(negedge clk);
        input_byte = b; is_key = 1'b0; input_request = 1'b1;
        t = 0;
        while (!input_ack && t < 50) begin @(negedge clk); t++; end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (input_ack !== 1'b0) begin n_bad++; $display("FAIL rstmid_ack_drop: got %b want 0", input_ack); end
        rst = 1'b0;
        obs_q.delete();
        t = 0;
        while (!input_ack && t < 50) begin @(negedge clk); t++; end
        n_cmp++; if (input_ack !== 1'b1) begin n_bad++; $display("FAIL rstmid_new_req: got %b want 1", input_ack); end
        input_request = 1'b0;
        repeat (6) @(negedge clk);
        n_cmp++; if (fifo_count !== 3'd1) begin n_bad++; $display("FAIL rstmid_count: got %0d want 1", fifo_count); end
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        n_cmp++; if (obs_q.size() != 1) begin n_bad++; $display("FAIL rstmid_npulses: got %0d want 1", obs_q.size()); end
    endtask

    task automatic test_random();
        bit ok;
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        obs_q.delete(); exp_q.delete();
        max_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            hs(8'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0), $urandom_range(0, 3), 1'b1, ok);
            n_cmp++; if (!ok) begin n_bad++; $display("FAIL rand_hs%0d: got no handshake want handshake", i); end
            #1;
            n_cmp++;
            if (int'(fifo_count) != exp_q.size() - obs_q.size()) begin
                n_bad++;
                $display("FAIL rand_count%0d: got %0d want %0d", i, fifo_count, exp_q.size() - obs_q.size());
            end
        end
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL rand_npulses: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL rand_data%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        n_cmp++; if (max_cnt > DEPTH) begin n_bad++; $display("FAIL rand_max_count: got %0d want <= %0d", max_cnt, DEPTH); end
    endtask

    task automatic test_timeout();
        int t;
        pulse_rst();
        out_ready = 1'b1;
        n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL to_initial: got %b want 0", timeout_err); end
        input_byte = 8'h3C; is_key = 1'b0; input_request = 1'b1;
        t = 0;
        while (!input_ack && t < 50) begin @(negedge clk); t++; end
        repeat (20) @(negedge clk);
`ifdef READER_TIMEOUT_EN
        n_cmp++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL to_set: got %b want 1", timeout_err); end
        input_request = 1'b0;
        repeat (8) @(negedge clk);
        n_cmp++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL to_sticky: got %b want 1", timeout_err); end
        n_cmp++; if (input_ack !== 1'b0) begin n_bad++; $display("FAIL to_ack_fall: got %b want 0", input_ack); end
        pulse_rst();
        n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL to_rst_clear: got %b want 0", timeout_err); end
`else
        n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL to_disabled: got %b want 0", timeout_err); end
        input_request = 1'b0;
        repeat (8) @(negedge clk);
        n_cmp++; if (input_ack !== 1'b0) begin n_bad++; $display("FAIL to_ack_fall: got %b want 0", input_ack); end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_long_hold();
        test_fifo_full();
        test_reset_hash();
        test_accept_en();
        test_rst_mid();
        test_random();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
